// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between the CPU (default owner),
// the UART loader and the UART dumper. The CPU has no stall input, so it is held in
// reset while a UART requester owns the port. Also latches the CPU halt encoding.
module mem_port_arbiter #(
  parameter int BUS_W          = 10,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic             clk_ext,
  input  logic             ext_rst,
  input  logic [BUS_W-1:0] cpu_bus,
  input  logic             cpu_rw,
  input  logic             cpu_commit,
  input  logic             ld_req,
  output logic             ld_gnt,
  input  logic [BUS_W-1:0] ld_bus,
  input  logic             ld_rw,
  input  logic             ld_commit,
  input  logic             dp_req,
  output logic             dp_gnt,
  input  logic [BUS_W-1:0] dp_bus,
  input  logic             dp_rw,
  input  logic             dp_commit,
  output logic [BUS_W-1:0] mem_bus,
  output logic             mem_rw,
  output logic             mem_commit,
  output logic             cpu_rst,
  output logic             cpu_halted,
  output logic [1:0]       owner
);

  localparam int CNT_W = (RELEASE_CYCLES < 2) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    CPU_RUN,
    CPU_DRAIN,
    LD_OWN,
    DP_OWN,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    SEL_CPU,
    SEL_LD,
    SEL_DP,
    SEL_IDLE
  } sel_t;

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             cpu_rst_q, cpu_rst_d;

  logic             any_req;
  logic             cpu_wr_addr;
  state_t           uart_next;

  // Next-state logic: arbitration, drain of a CPU write, release hold-off and halt latch
  always_comb begin
    any_req     = ld_req | dp_req;
    uart_next   = dp_req ? DP_OWN : LD_OWN;
    cpu_wr_addr = !cpu_rw && !cpu_commit && !halted_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;

    case (state_q)
      CPU_RUN: begin
        if (any_req) begin
          state_d = cpu_wr_addr ? CPU_DRAIN : uart_next;
        end else if (cpu_rw && cpu_commit) begin
          halted_d = 1'b1;
        end
      end
      CPU_DRAIN: begin
        state_d = any_req ? uart_next : CPU_RUN;
      end
      LD_OWN: begin
        if (!ld_req) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      DP_OWN: begin
        if (!dp_req) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = any_req ? uart_next : CPU_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = CNT_LOAD;
      end
    endcase

    if (state_d == LD_OWN || state_d == DP_OWN) begin
      halted_d = 1'b0;
    end

    cpu_rst_d = !(state_d == CPU_RUN || state_d == CPU_DRAIN);

    case (state_d)
      CPU_RUN:   sel_d = halted_d ? SEL_IDLE : SEL_CPU;
      CPU_DRAIN: sel_d = SEL_CPU;
      LD_OWN:    sel_d = SEL_LD;
      DP_OWN:    sel_d = SEL_DP;
      default:   sel_d = SEL_IDLE;
    endcase
  end

  // State, counter, halt flag, CPU reset and bus select registers; reset parks in HOLD
  always_ff @(posedge clk_ext or posedge ext_rst) begin
    if (ext_rst) begin
      state_q   <= HOLD;
      cnt_q     <= CNT_LOAD;
      halted_q  <= 1'b0;
      cpu_rst_q <= 1'b1;
      sel_q     <= SEL_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halted_q  <= halted_d;
      cpu_rst_q <= cpu_rst_d;
      sel_q     <= sel_d;
    end
  end

  // Memory port mux driven from the registered select; idle is a harmless read of 0
  always_comb begin
    mem_bus    = '0;
    mem_rw     = 1'b1;
    mem_commit = 1'b0;
    case (sel_q)
      SEL_CPU: begin
        mem_bus    = cpu_bus;
        mem_rw     = cpu_rw;
        mem_commit = cpu_commit;
      end
      SEL_LD: begin
        mem_bus    = ld_bus;
        mem_rw     = ld_rw;
        mem_commit = ld_commit;
      end
      SEL_DP: begin
        mem_bus    = dp_bus;
        mem_rw     = dp_rw;
        mem_commit = dp_commit;
      end
      default: begin
        mem_bus    = '0;
        mem_rw     = 1'b1;
        mem_commit = 1'b0;
      end
    endcase
  end

  // Owner code decoded from the registered state so it never glitches
  always_comb begin
    case (state_q)
      CPU_RUN, CPU_DRAIN: owner = 2'd0;
      LD_OWN:             owner = 2'd1;
      DP_OWN:             owner = 2'd2;
      default:            owner = 2'd3;
    endcase
  end

  assign ld_gnt     = (state_q == LD_OWN);
  assign dp_gnt     = (state_q == DP_OWN);
  assign cpu_rst    = cpu_rst_q;
  assign cpu_halted = halted_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus pushes hand-computed expectations into a
// scoreboard queue tagged with the cycle they are due; a monitor pops and compares them.
module tb_mem_port_arbiter;

  localparam int BUS_W = 10;
  localparam logic [BUS_W-1:0] LD_BUS    = 10'h155;
  localparam logic             LD_RW     = 1'b0;
  localparam logic             LD_COMMIT = 1'b0;
  localparam logic [BUS_W-1:0] DP_BUS    = 10'h3C3;
  localparam logic             DP_RW     = 1'b1;
  localparam logic             DP_COMMIT = 1'b0;

  logic             clk_ext;
  logic             ext_rst;
  logic [BUS_W-1:0] cpu_bus;
  logic             cpu_rw;
  logic             cpu_commit;
  logic             ld_req;
  logic             ld_gnt;
  logic [BUS_W-1:0] ld_bus;
  logic             ld_rw;
  logic             ld_commit;
  logic             dp_req;
  logic             dp_gnt;
  logic [BUS_W-1:0] dp_bus;
  logic             dp_rw;
  logic             dp_commit;
  logic [BUS_W-1:0] mem_bus;
  logic             mem_rw;
  logic             mem_commit;
  logic             cpu_rst;
  logic             cpu_halted;
  logic [1:0]       owner;

  typedef struct {
    string            name;
    int               cyc;
    bit               mid;
    logic             ld_gnt;
    logic             dp_gnt;
    logic [1:0]       owner;
    logic             cpu_rst;
    logic             halted;
    logic [BUS_W-1:0] bus;
    logic             rw;
    logic             commit;
  } exp_t;

  exp_t sb_q[$];
  int   cycle       = 0;
  int   check_count = 0;
  int   error_count = 0;
  bit   stim_done   = 1'b0;

  mem_port_arbiter #(
    .BUS_W(BUS_W),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk_ext(clk_ext),
    .ext_rst(ext_rst),
    .cpu_bus(cpu_bus),
    .cpu_rw(cpu_rw),
    .cpu_commit(cpu_commit),
    .ld_req(ld_req),
    .ld_gnt(ld_gnt),
    .ld_bus(ld_bus),
    .ld_rw(ld_rw),
    .ld_commit(ld_commit),
    .dp_req(dp_req),
    .dp_gnt(dp_gnt),
    .dp_bus(dp_bus),
    .dp_rw(dp_rw),
    .dp_commit(dp_commit),
    .mem_bus(mem_bus),
    .mem_rw(mem_rw),
    .mem_commit(mem_commit),
    .cpu_rst(cpu_rst),
    .cpu_halted(cpu_halted),
    .owner(owner)
  );

  // Free-running clock, period 10
  initial begin
    clk_ext = 1'b0;
    forever #5 clk_ext = ~clk_ext;
  end

  // Drive one cycle of inputs on the falling edge
  task automatic applyStimulus(input logic rst, input logic ld, input logic dp,
                               input logic [BUS_W-1:0] cbus, input logic crw,
                               input logic ccom);
    @(negedge clk_ext);
    ext_rst    = rst;
    ld_req     = ld;
    dp_req     = dp;
    cpu_bus    = cbus;
    cpu_rw     = crw;
    cpu_commit = ccom;
  endtask

  // Offset 0 checks later in this same cycle, offset 1 after the next rising edge
  task automatic expectOutput(input string name, input int offset,
                              input logic lg, input logic dg, input logic [1:0] own,
                              input logic crst, input logic hlt,
                              input logic [BUS_W-1:0] bus, input logic rw,
                              input logic com);
    exp_t e;
    e.name    = name;
    e.cyc     = cycle + offset;
    e.mid     = (offset == 0);
    e.ld_gnt  = lg;
    e.dp_gnt  = dg;
    e.owner   = own;
    e.cpu_rst = crst;
    e.halted  = hlt;
    e.bus     = bus;
    e.rw      = rw;
    e.commit  = com;
    sb_q.push_back(e);
  endtask

  task automatic expectHold(input string name, input int offset);
    expectOutput(name, offset, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic expectCpu(input string name, input int offset,
                           input logic [BUS_W-1:0] bus, input logic rw, input logic com);
    expectOutput(name, offset, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, bus, rw, com);
  endtask

  task automatic expectLd(input string name, input int offset);
    expectOutput(name, offset, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, LD_BUS, LD_RW, LD_COMMIT);
  endtask

  task automatic expectDp(input string name, input int offset);
    expectOutput(name, offset, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, DP_BUS, DP_RW, DP_COMMIT);
  endtask

  // Drop all requests: four idle HOLD cycles, then the CPU owns the port again
  task automatic releaseToCpu(input string name);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
      expectHold({name, "_hold"}, 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectCpu({name, "_cpu"}, 1, 10'h2A5, 1'b1, 1'b0);
  endtask

  // Compare one scoreboard entry against the live DUT outputs
  task automatic checkOutput(input exp_t e, input bit late);
    check_count++;
    if (late || ld_gnt !== e.ld_gnt || dp_gnt !== e.dp_gnt || owner !== e.owner ||
        cpu_rst !== e.cpu_rst || cpu_halted !== e.halted || mem_bus !== e.bus ||
        mem_rw !== e.rw || mem_commit !== e.commit) begin
      error_count++;
      $display("[TB] FAIL %s cyc=%0d late=%0d got ld_gnt=%b dp_gnt=%b owner=%0d cpu_rst=%b halted=%b bus=%h rw=%b commit=%b expected ld_gnt=%b dp_gnt=%b owner=%0d cpu_rst=%b halted=%b bus=%h rw=%b commit=%b",
               e.name, e.cyc, late, ld_gnt, dp_gnt, owner, cpu_rst, cpu_halted,
               mem_bus, mem_rw, mem_commit, e.ld_gnt, e.dp_gnt, e.owner,
               e.cpu_rst, e.halted, e.bus, e.rw, e.commit);
    end
  endtask

  // Monitor: pops due entries 1 time unit after each clock edge, then prints the summary
  initial begin
    int  drain_cycles;
    bit  on_rise;
    bit  due;
    bit  late;
    exp_t e;
    drain_cycles = 0;
    while (1'b1) begin
      @(clk_ext);
      #1;
      on_rise = clk_ext;
      if (on_rise) cycle++;
      due = 1'b1;
      while (sb_q.size() > 0 && due) begin
        e    = sb_q[0];
        late = (e.cyc < cycle) || (e.cyc == cycle && on_rise && e.mid) ? 1'b0 : 1'b0;
        if (e.cyc < cycle) begin
          late = 1'b1;
        end else if (e.cyc == cycle && (!on_rise || !e.mid)) begin
          late = 1'b0;
        end else begin
          due = 1'b0;
        end
        if (due) begin
          void'(sb_q.pop_front());
          checkOutput(e, late);
        end
      end
      if (stim_done) begin
        if (sb_q.size() == 0) break;
        drain_cycles++;
        if (drain_cycles > 20) begin
          error_count++;
          $display("[TB] FAIL scoreboard_drain pending=%0d expected 0", sb_q.size());
          break;
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

  // Directed stimulus with hand-computed expectations
  initial begin
    ext_rst    = 1'b1;
    cpu_bus    = '0;
    cpu_rw     = 1'b1;
    cpu_commit = 1'b0;
    ld_req     = 1'b0;
    dp_req     = 1'b0;
    ld_bus     = LD_BUS;
    ld_rw      = LD_RW;
    ld_commit  = LD_COMMIT;
    dp_bus     = DP_BUS;
    dp_rw      = DP_RW;
    dp_commit  = DP_COMMIT;

    $display("[TB] reset state");
    applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    expectHold("rst_mid", 0);
    expectHold("rst_edge", 1);

    $display("[TB] reset release hold-off");
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectHold("rel_c0", 0);
    expectHold("rel_c1", 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectHold("rel_c2", 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectHold("rel_c3", 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectCpu("rel_cpu", 1, 10'h2A5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h1F0, 1'b1, 1'b0);
    expectCpu("cpu_track", 1, 10'h1F0, 1'b1, 1'b0);

    $display("[TB] loader grant without drain");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectCpu("ld_pre", 0, 10'h2A5, 1'b1, 1'b0);
    expectLd("ld_gnt", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectLd("ld_stay", 1);
    releaseToCpu("ld_rel");

    $display("[TB] dumper grant with CPU write drain");
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h020, 1'b0, 1'b0);
    expectCpu("drain_addr_pre", 0, 10'h020, 1'b0, 1'b0);
    expectCpu("drain_addr", 1, 10'h020, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h045, 1'b0, 1'b1);
    expectCpu("drain_data", 0, 10'h045, 1'b0, 1'b1);
    expectDp("dp_gnt", 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 10'h2A5, 1'b1, 1'b0);
    expectDp("dp_stay", 1);
    releaseToCpu("dp_rel");

    $display("[TB] simultaneous requests, dumper first then loader");
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h2A5, 1'b1, 1'b0);
    expectDp("both_dp", 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 10'h2A5, 1'b1, 1'b0);
    expectDp("both_dp_stay", 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
      expectHold("handover_hold", 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectLd("handover_ld", 1);
    releaseToCpu("handover_rel");

    $display("[TB] CPU halt");
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b1);
    expectCpu("halt_pre", 0, 10'h3FF, 1'b1, 1'b1);
    expectOutput("halt_set", 1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 10'h123, 1'b0, 1'b0);
    expectOutput("halt_sticky", 1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h123, 1'b0, 1'b0);
    expectLd("halt_ld_clear", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectLd("halt_ld_stay", 1);

    $display("[TB] reset during loader ownership");
    applyStimulus(1'b1, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectHold("rst_async", 0);
    expectHold("rst_async_edge", 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
      expectHold("rst_ld_hold", 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectLd("rst_ld_regrant", 1);
    releaseToCpu("rst_ld_rel");

    $display("[TB] request and halt in the same cycle");
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h3FF, 1'b1, 1'b1);
    expectLd("req_beats_halt", 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10'h2A5, 1'b1, 1'b0);
    expectLd("req_beats_halt_stay", 1);
    releaseToCpu("final_rel");

    stim_done = 1'b1;
  end

endmodule
